// File: rtl/btn_conditioner.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce FSM, press/release strobes.
// Optional toggle output enabled by defining BTN_COND_TOGGLE_EN.
module btn_conditioner #(
  parameter int DB_CYCLES = 1000000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btnIN,
  output logic outSig,
  output logic pressPulse,
  output logic releasePulse,
  output logic toggleOut
);

  // state        | meaning
  // IDLE         | released level accepted, waiting for a high sample
  // PRESS_WAIT   | high seen, counting stable high samples
  // PRESSED      | pressed level accepted, waiting for a low sample
  // RELEASE_WAIT | low seen, counting stable low samples
  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  state_t           state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btnIN;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      outSig       <= 1'b0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
    end else begin
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state      <= PRESSED;
            outSig     <= 1'b1;
            pressPulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A high sample here is a release bounce: go back without a pulse.
          if (sync2) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state        <= IDLE;
            outSig       <= 1'b0;
            releasePulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef BTN_COND_TOGGLE_EN
  // Flips on the same edge that raises pressPulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggleOut <= 1'b0;
    end else if (state == PRESS_WAIT && sync2 && cnt == CNT_LAST) begin
      toggleOut <= ~toggleOut;
    end
  end
`else
  assign toggleOut = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner (DB_CYCLES=4) using a run-length
// reference model whose predictions are queued and compared two edges later.
module tb_btn_conditioner;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btnIN = 1'b0;
  logic outSig, pressPulse, releasePulse, toggleOut;

  btn_conditioner #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .btnIN(btnIN),
    .outSig(outSig),
    .pressPulse(pressPulse),
    .releasePulse(releasePulse),
    .toggleOut(toggleOut)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_press = 0;
  logic [3:0] exp_q[$];
  bit m_lvl = 1'b0;
  bit m_tog = 1'b0;
  int m_run = 0;

  task automatic check_val(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got {out,press,rel,tog}=%b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  // Drive one sample, advance one edge, update model, compare outputs.
  task automatic step(input bit b, input bit r);
    logic [3:0] exp_now;
    bit p, q;
    @(negedge clk);
    btnIN = b;
    rst   = r;
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_q.push_back(4'b0000);
      exp_q.push_back(4'b0000);
      m_lvl   = 1'b0;
      m_run   = 0;
      m_tog   = 1'b0;
      exp_now = 4'b0000;
    end else begin
      p = 1'b0;
      q = 1'b0;
      if (b != m_lvl) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_lvl = b;
          m_run = 0;
          if (b) begin
            p = 1'b1;
`ifdef BTN_COND_TOGGLE_EN
            m_tog = ~m_tog;
`endif
          end else begin
            q = 1'b1;
          end
        end
      end else begin
        m_run = 0;
      end
      exp_q.push_back({m_lvl, p, q, m_tog});
      exp_now = exp_q.pop_front();
    end
    #1;
    if (pressPulse === 1'b1) n_press++;
    check_val("outs", {outSig, pressPulse, releasePulse, toggleOut}, exp_now);
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    int base;
    bit v;
    // reset and clean press / bounce-in-release / clean release
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    hold(1'b1, 20);
    hold(1'b0, 2);
    hold(1'b1, 5);
    hold(1'b0, 12);
    // press bounce pattern then real press
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    hold(1'b0, 4);
    hold(1'b1, 10);
    // reset while pressed and held; debounce reruns
    step(1'b1, 1'b1);
    hold(1'b1, 12);
    hold(1'b0, 12);
    // reset landing on the accept edge suppresses the pulse
    hold(1'b1, DB + 2);
    step(1'b1, 1'b1);
    hold(1'b0, 6);
    // three accepted presses for the toggle output
    base = n_press;
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 9);
      hold(1'b0, 9);
    end
    check_val("press_count", 4'(n_press - base), 4'd3);
    // long hold gives exactly one pulse
    base = n_press;
    hold(1'b1, 40);
    check_val("long_hold", 4'(n_press - base), 4'd1);
    hold(1'b0, 10);
    // random runs with occasional reset
    for (int s = 0; s < 60; s++) begin
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) step(v, 1'b1);
      hold(v, $urandom_range(1, 8));
    end
    hold(1'b0, 10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter DB_CYCLES, default 1000000; number of consecutive stable synchronized samples required to accept a level change (10 ms at 100 MHz); SHALL be >= 2.
REQ-002 Parameter CNT_W, default 20; stability counter width; SHALL satisfy 2^CNT_W > DB_CYCLES-1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 btnIN  input  1  raw asynchronous pushbutton level, bouncy.
REQ-006 outSig  output  1  debounced registered button level, feeds downstream FSM.
REQ-007 pressPulse  output  1  one-cycle strobe on accepted 0->1 change.
REQ-008 releasePulse  output  1  one-cycle strobe on accepted 1->0 change.
REQ-009 toggleOut  output  1  level inverting on each accepted press (feature-gated, REQ-030).

Function
REQ-010 btnIN SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 drives the FSM.
REQ-011 FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; outSig=1 exactly in PRESSED and RELEASE_WAIT.
REQ-012 IDLE: sync2=1 -> PRESS_WAIT, cnt<=0; else stay.
REQ-013 PRESS_WAIT: sync2=0 -> IDLE, cnt<=0 (bounce rejected, no pulse); cnt==DB_CYCLES-1 -> PRESSED, pressPulse<=1; else cnt<=cnt+1.
REQ-014 PRESSED: sync2=0 -> RELEASE_WAIT, cnt<=0; else stay.
REQ-015 RELEASE_WAIT: sync2=1 -> PRESSED, cnt<=0 (no pulse, outSig stays 1); cnt==DB_CYCLES-1 -> IDLE, releasePulse<=1; else cnt<=cnt+1.
REQ-016 Accept latency: btnIN held high from sampling edge k SHALL give outSig=1 and pressPulse=1 after edge k+DB_CYCLES+2 (DB_CYCLES+3 edges inclusive); release latency identical.
REQ-017 Any sync2 excursion shorter than DB_CYCLES cycles SHALL produce no change on outSig and no pulse.
REQ-018 pressPulse and releasePulse SHALL each be high for exactly one cycle per accepted change and SHALL never be high together.
REQ-019 All outputs SHALL be driven directly from flops; no combinational path from btnIN to any output.
REQ-020 cnt SHALL never exceed DB_CYCLES-1; no wrap.
REQ-021 Persistent button hold SHALL produce exactly one pressPulse regardless of duration.

Reset
REQ-022 rst=1 at an edge SHALL set sync1=sync2=0, state=IDLE, cnt=0, outSig=0, pressPulse=0, releasePulse=0, toggleOut=0.
REQ-023 rst SHALL override every transition in the same edge, including an accept edge; no pulse emitted that cycle.
REQ-024 Reset mid-press (PRESSED, button still held): after rst deasserts, full press debounce SHALL rerun and emit a fresh pressPulse; no releasePulse for the aborted press.

Configuration
REQ-030 Macro BTN_COND_TOGGLE_EN: defined -> toggleOut flops and inverts on the edge that sets pressPulse; undefined -> toggleOut tied to constant 0, port retained, no toggle flop synthesized.

Verification (DB_CYCLES=4 unless noted)
REQ-040 Clean press: rst 2 cycles, btnIN 0->1 held 20 cycles -> outSig rises 7 edges after first high sample, pressPulse high exactly 1 cycle, releasePulse 0.
REQ-041 Bounce: btnIN pattern 1,0,1,1,0 then 0 -> outSig stays 0, no pulses; then hold 1 for 10 cycles -> single pressPulse.
REQ-042 Release: from PRESSED drop btnIN to 0 for 2 cycles then 1 -> outSig stays 1, no releasePulse; then 0 held 10 cycles -> outSig falls after 7 edges, releasePulse 1 cycle.
REQ-043 Reset mid-operation: rst asserted in PRESSED with btnIN=1 -> all outputs 0 next cycle; after deassert, pressPulse reappears 7 edges later.
REQ-044 Toggle: with BTN_COND_TOGGLE_EN, 3 accepted presses -> toggleOut 0->1->0->1 coinciding with each pressPulse; without macro toggleOut==0 throughout.
REQ-045 Default params (DB_CYCLES=1000000): hold 999990 cycles then release -> no pulse; hold 1000010 -> one pressPulse.
